// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Radix-4 Booth digit selections: 0, +A, +2A, -A, -2A
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_e;

    // Number of Booth steps for a given operand width (one per 2-bit digit)
    function automatic int steps_of(input int w);
        return w / 2;
    endfunction

    // Step-counter width for a given operand width; never narrower than 1 bit
    function automatic int step_w_of(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

    localparam int WIDTH_DEF = 16;
    localparam int STEPS     = steps_of(WIDTH_DEF);
    localparam int STEP_W    = step_w_of(WIDTH_DEF);

    // Window {b[2i+1], b[2i], b[2i-1]} -> digit -2*b[2i+1] + b[2i] + b[2i-1]
    function automatic booth_sel_e booth_decode(input logic [2:0] win);
        booth_sel_e sel;
        case (win)
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
// Negative digits are produced as the one's complement of the selected
// multiple; the +1 that completes the two's complement is exported as
// neg so the accumulator can fold it in at the digit's weight.
module booth_pp_gen
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic        [2:0]       win,
    output logic signed [WIDTH+1:0] pp,
    output logic                    neg
);

    booth_sel_e              sel;
    logic signed [WIDTH+1:0] a_ext;
    logic signed [WIDTH+1:0] mag;

    // Select the 0 / A / 2A multiple and conditionally invert it
    always_comb begin
        sel   = booth_decode(win);
        a_ext = {{2{a[WIDTH-1]}}, a};
        mag   = '0;
        neg   = 1'b0;
        case (sel)
            SEL_POS1: mag = a_ext;
            SEL_POS2: mag = a_ext <<< 1;
            SEL_NEG1: begin
                mag = a_ext;
                neg = 1'b1;
            end
            SEL_NEG2: begin
                mag = a_ext <<< 1;
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp = mag ^ {(WIDTH + 2){neg}};
    end

endmodule

// File: rtl/app_mult_signed16_seq.sv
// Sequential signed WIDTHxWIDTH multiplier with valid/ready on both sides.
// One radix-4 Booth digit of b is retired per RUN cycle through a single
// shared partial-product generator.
module app_mult_signed16_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      busy
);

    localparam int N_STEPS = steps_of(WIDTH);
    localparam int CNT_W   = step_w_of(WIDTH);
    localparam int ACC_W   = 2 * WIDTH;

    state_e                  state;
    state_e                  state_nxt;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic [CNT_W-1:0]        step;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_nxt;
    logic [ACC_W-1:0]        pp_ext;
    logic [WIDTH:0]          b_ext;
    logic [2:0]              win;
    logic signed [WIDTH+1:0] pp;
    logic                    pp_neg;
    logic                    accept;
    logic                    last_step;
    logic                    release_out;

    assign accept      = in_valid && in_ready;
    assign last_step   = (state == RUN) && (step == CNT_W'(N_STEPS - 1));
    assign release_out = out_valid && out_ready;

    // b with the implicit b[-1] = 0 appended below bit 0
    assign b_ext = {b_r, 1'b0};
    assign win   = b_ext[{step, 1'b0} +: 3];

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .a   (a_r),
        .win (win),
        .pp  (pp),
        .neg (pp_neg)
    );

    // Weight the partial product by 4^step and add the deferred negate carry
    always_comb begin
        pp_ext  = {{(ACC_W - WIDTH - 2){pp[WIDTH+1]}}, pp};
        acc_nxt = acc + (pp_ext << {step, 1'b0})
                      + (ACC_W'(pp_neg) << {step, 1'b0});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = RUN;
            RUN:     if (last_step)   state_nxt = DONE;
            DONE:    if (release_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operand capture, step counter, accumulator and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            step    <= '0;
            acc     <= '0;
            product <= '0;
        end else if (accept) begin
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            step <= '0;
        end else if (state == RUN) begin
            acc  <= acc_nxt;
            step <= step + CNT_W'(1);
            if (last_step) product <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_app_mult_signed16_seq.sv
// Directed bench for app_mult_signed16_seq.
module tb_app_mult_signed16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    app_mult_signed16_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp);
        int w;
        int cyc;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd8);
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] expq[$];
        int          acc_t[$];
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [31:0] e;
        logic [31:0] held;
        logic        acc_now;
        logic        res_now;
        logic [31:0] prod_now;
        int          n_acc;
        int          n_res;
        int          cyc;
        int          stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic and sign corners
        run_op("basic_3x5", 16'd3, 16'd5, 32'h0000_000F);
        run_op("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000);
        run_op("max_x_min", 16'h7FFF, 16'h8000, 32'hC000_8000);
        run_op("m1_x_m1", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
        run_op("zero_x_min", 16'h0000, 16'h8000, 32'h0000_0000);

        // Backpressure: 12 * -3 = -36, held while out_ready is low
        tick();
        a        = 16'd12;
        b        = 16'hFFFD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'd8);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_product", 64'(product), 64'h0000_0000_FFFF_FFDC);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = (k % 2 == 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_busy", 64'(busy), 64'd0);
        check("bp_product_kept", 64'(product), 64'h0000_0000_FFFF_FFDC);

        // Back-to-back: 20 random pairs with both handshakes held high
        a         = 16'($urandom);
        b         = 16'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_acc     = 0;
        n_res     = 0;
        cyc       = 0;
        while (n_res < 20 && cyc < 400) begin
            acc_now  = in_valid && in_ready;
            res_now  = out_valid;
            prod_now = product;
            sa       = a;
            sb       = b;
            e        = sa * sb;
            tick();
            cyc++;
            if (acc_now) begin
                expq.push_back(e);
                acc_t.push_back(cyc);
                n_acc++;
                if (n_acc == 20) in_valid = 1'b0;
                else begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                end
            end
            if (res_now) begin
                held = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
                check("b2b_product", 64'(prod_now), 64'(held));
                n_res++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_results", 64'(n_res), 64'd20);
        for (int i = 1; i < acc_t.size(); i++)
            check("b2b_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'd10);

        // Operand disturbance during RUN: 100 * -7 = -700
        tick();
        a        = 16'd100;
        b        = 16'hFFF9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = ~a;
            b = ~b;
            tick();
        end
        check("dist_out_valid", 64'(out_valid), 64'd1);
        check("dist_product", 64'(product), 64'h0000_0000_FFFF_FD44);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the 4th RUN cycle discards the operation
        a        = 16'd9;
        b        = 16'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_product", 64'(product), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", 64'(in_ready), 64'd1);
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || busy) stale++;
            tick();
        end
        check("mid_rst_no_stale", 64'(stale), 64'd0);
        run_op("after_rst_m2x3", 16'hFFFE, 16'd3, 32'hFFFF_FFFA);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
